instruction_dispatcher: RTL and testbench

Buffers video-processor instructions written by the host (dataA/dataB pairs) and issues them one at a time to the instruction decoder. It generates the decoder's `clk_en` strobe and `new_instruction` qualifier. Memory-write instructions are held until vertical blanking, and polygon instructions are held until the co-processor is ready. The block sits between the host bus bridge and the decoder/control unit of the graphics processor.

---
 rtl/instruction_dispatcher_pkg.sv | 49 ++++
 rtl/instruction_fifo.sv | 80 ++++++++
 rtl/instruction_dispatcher.sv | 147 ++++++++++++++
 tb/tb_instruction_dispatcher.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_dispatcher_pkg.sv
// Purpose: shared opcode constants, FSM state encoding, instruction payload
//          type and opcode gating helpers for the instruction dispatcher.
package instruction_dispatcher_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned OPCODE_W = 4;
    localparam int unsigned ENTRY_W  = 2 * DATA_W;
    localparam int unsigned DROP_W   = 8;

    localparam logic [OPCODE_W-1:0] OP_SPRITE_POS = OPCODE_W'(0);
    localparam logic [OPCODE_W-1:0] OP_SPRITE_MEM = OPCODE_W'(1);
    localparam logic [OPCODE_W-1:0] OP_BG_MEM     = OPCODE_W'(2);
    localparam logic [OPCODE_W-1:0] OP_POLYGON    = OPCODE_W'(3);
    localparam logic [OPCODE_W-1:0] OP_NOP        = OPCODE_W'(15);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ISSUE = 2'd2,
        ST_WAIT  = 2'd3
    } disp_state_e;

    // One FIFO entry: word A sits in the upper half
    typedef struct packed {
        logic [DATA_W-1:0] data_a;
        logic [DATA_W-1:0] data_b;
    } instr_t;

    // Only opcodes 0..3 are executable; anything above (including NOP) is dropped
    function automatic logic op_valid(input logic [OPCODE_W-1:0] op);
        return (op <= OP_POLYGON);
    endfunction

    // Gate each valid opcode on the external condition it depends on
    function automatic logic op_gate_open(input logic [OPCODE_W-1:0] op,
                                          input logic                blank,
                                          input logic                coproc);
        logic open;
        open = 1'b0;
        case (op)
            OP_SPRITE_POS:            open = 1'b1;
            OP_SPRITE_MEM, OP_BG_MEM: open = blank;
            OP_POLYGON:               open = coproc;
            default:                  open = 1'b0;
        endcase
        return open;
    endfunction

endpackage

// File: rtl/instruction_fifo.sv
// Purpose: single-clock synchronous FIFO with registered full/empty flags and
//          a combinational head-of-queue read port.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   wr_en_i, wr_data_i - push request and data (ignored when full unless popping)
//   rd_en_i           - pop request (ignored when empty)
//   rd_data_c         - current head entry, straight from storage
//   full_o, empty_o   - registered occupancy flags
module instruction_fifo #(
    parameter int unsigned WIDTH  = 64,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_c,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PTR_W = ADDR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             rd_ok_c;
    logic             wr_ok_c;

    // A push into a full FIFO is allowed only when a pop frees the slot this cycle
    assign rd_ok_c = rd_en_i && !empty_q;
    assign wr_ok_c = wr_en_i && (!full_q || rd_ok_c);

    assign rd_data_c = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Next pointers and flags; the extra MSB distinguishes full from empty
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_ok_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd_ok_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[ADDR_W] != rd_ptr_d[ADDR_W]) &&
                  (wr_ptr_d[ADDR_W-1:0] == rd_ptr_d[ADDR_W-1:0]);
    end

    // Pointer and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage needs no reset: pointers alone define valid contents
    always_ff @(posedge clk) begin
        if (wr_ok_c) begin
            mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data_i;
        end
    end

    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/instruction_dispatcher.sv
// Purpose: buffers host-written instruction pairs and issues them in order to
//          the decoder, holding memory writes until vertical blank and polygon
//          instructions until the co-processor is ready.
// Ports:
//   clk, reset           - clock, asynchronous active-low reset
//   wr_en, dataA, dataB  - host push of one instruction (dataA[3:0] = opcode)
//   screen_blank         - vertical blanking, opens opcodes 1 and 2
//   coproc_ready         - co-processor ready, opens opcode 3
//   unit_ready           - control unit can accept an instruction
//   out_dataA, out_dataB - instruction presented to the decoder
//   out_clk_en           - one-cycle issue strobe
//   out_new_instruction  - qualifier coincident with out_clk_en
//   fifo_full, fifo_empty- FIFO occupancy flags
//   busy                 - dispatcher not idle
//   drop_count           - saturating count of discarded invalid opcodes
module instruction_dispatcher
    import instruction_dispatcher_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] dataA,
    input  logic [DATA_W-1:0] dataB,
    input  logic              screen_blank,
    input  logic              coproc_ready,
    input  logic              unit_ready,
    output logic [DATA_W-1:0] out_dataA,
    output logic [DATA_W-1:0] out_dataB,
    output logic              out_clk_en,
    output logic              out_new_instruction,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              busy,
    output logic [DROP_W-1:0] drop_count
);

    disp_state_e       state_q, state_d;
    logic [DATA_W-1:0] data_a_q, data_a_d;
    logic [DATA_W-1:0] data_b_q, data_b_d;
    logic              strobe_q, strobe_d;
    logic              busy_q, busy_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    instr_t            wr_instr_c;
    instr_t            head_c;
    logic              pop_c;
    logic              fifo_full_c;
    logic              fifo_empty_c;
    logic [OPCODE_W-1:0] opcode_c;

    assign wr_instr_c = '{data_a: dataA, data_b: dataB};
    assign opcode_c   = data_a_q[OPCODE_W-1:0];

    instruction_fifo #(
        .WIDTH  (ENTRY_W),
        .DEPTH  (FIFO_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .wr_en_i   (wr_en),
        .wr_data_i (wr_instr_c),
        .rd_en_i   (pop_c),
        .rd_data_c (head_c),
        .full_o    (fifo_full_c),
        .empty_o   (fifo_empty_c)
    );

    // Next-state, data latch, strobe and drop counter
    always_comb begin
        state_d  = state_q;
        data_a_d = data_a_q;
        data_b_d = data_b_q;
        strobe_d = 1'b0;
        drop_d   = drop_q;
        pop_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c) begin
                    pop_c    = 1'b1;
                    data_a_d = head_c.data_a;
                    data_b_d = head_c.data_b;
                    state_d  = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!op_valid(opcode_c)) begin
                    if (drop_q != {DROP_W{1'b1}}) begin
                        drop_d = drop_q + DROP_W'(1);
                    end
                    state_d = ST_IDLE;
                end else if (op_gate_open(opcode_c, screen_blank, coproc_ready) &&
                             unit_ready) begin
                    // Strobe is registered, so it is raised on entry to ISSUE
                    strobe_d = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (unit_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            data_a_q <= '0;
            data_b_q <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            data_a_q <= data_a_d;
            data_b_q <= data_b_d;
            strobe_q <= strobe_d;
            busy_q   <= busy_d;
            drop_q   <= drop_d;
        end
    end

    assign out_dataA           = data_a_q;
    assign out_dataB           = data_b_q;
    assign out_clk_en          = strobe_q;
    assign out_new_instruction = strobe_q;
    assign fifo_full           = fifo_full_c;
    assign fifo_empty          = fifo_empty_c;
    assign busy                = busy_q;
    assign drop_count          = drop_q;

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Purpose: scoreboard bench for instruction_dispatcher. Stimulus pushes the
//          expected issued pair into a queue; a monitor pops and compares on
//          every decoder strobe.
module tb_instruction_dispatcher;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [31:0] dataA;
    logic [31:0] dataB;
    logic        screen_blank;
    logic        coproc_ready;
    logic        unit_ready;
    logic [31:0] out_dataA;
    logic [31:0] out_dataB;
    logic        out_clk_en;
    logic        out_new_instruction;
    logic        fifo_full;
    logic        fifo_empty;
    logic        busy;
    logic [7:0]  drop_count;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] exp_q[$];
    logic        prev_en = 1'b0;

    instruction_dispatcher #(
        .FIFO_DEPTH (16),
        .ADDR_W     (4)
    ) dut (
        .clk                 (clk),
        .reset               (rst_n),
        .wr_en               (wr_en),
        .dataA               (dataA),
        .dataB               (dataB),
        .screen_blank        (screen_blank),
        .coproc_ready        (coproc_ready),
        .unit_ready          (unit_ready),
        .out_dataA           (out_dataA),
        .out_dataB           (out_dataB),
        .out_clk_en          (out_clk_en),
        .out_new_instruction (out_new_instruction),
        .fifo_full           (fifo_full),
        .fifo_empty          (fifo_empty),
        .busy                (busy),
        .drop_count          (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe must match the oldest expected instruction
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst_n) begin
            if (prev_en) check("strobe_one_cycle", 64'(out_clk_en), 64'd0);
            if (out_clk_en) begin
                check("new_instruction", 64'(out_new_instruction), 64'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_strobe: got dataA=%h dataB=%h, expected no issue",
                             out_dataA, out_dataB);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_dataA", 64'(out_dataA), 64'(e[63:32]));
                    check("issue_dataB", 64'(out_dataB), 64'(e[31:0]));
                end
            end
            prev_en = out_clk_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input bit expect_issue, input bit wait_space);
        int n;
        @(negedge clk);
        if (wait_space) begin
            n = 0;
            while (fifo_full && n < 1000) begin
                @(negedge clk);
                n++;
            end
            check("push_space_timeout", 64'(n >= 1000), 64'd0);
        end
        wr_en = 1'b1;
        dataA = a;
        dataB = b;
        if (expect_issue) exp_q.push_back({a, b});
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input string name, input int max);
        int n;
        n = 0;
        while (!(fifo_empty && !busy && exp_q.size() == 0) && n < max) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(n >= max), 64'd0);
    endtask

    task automatic no_strobe_for(input string name, input int cycles);
        bit seen;
        seen = 1'b0;
        repeat (cycles) begin
            @(negedge clk);
            if (out_clk_en) seen = 1'b1;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n        = 1'b0;
        wr_en        = 1'b0;
        dataA        = '0;
        dataB        = '0;
        screen_blank = 1'b0;
        coproc_ready = 1'b0;
        unit_ready   = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_clk_en", 64'(out_clk_en), 64'd0);
        check("rst_fifo_empty", 64'(fifo_empty), 64'd1);
        check("rst_fifo_full", 64'(fifo_full), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop_count), 64'd0);
        check("rst_dataA", 64'(out_dataA), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single issue: strobe after edge k+2, busy clears after edge k+4
        push(32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1);
        check("t1_k_empty", 64'(fifo_empty), 64'd0);
        check("t1_k_strobe", 64'(out_clk_en), 64'd0);
        @(negedge clk);
        check("t1_k1_busy", 64'(busy), 64'd1);
        check("t1_k1_dataB", 64'(out_dataB), 64'h1234_5678);
        check("t1_k1_strobe", 64'(out_clk_en), 64'd0);
        check("t1_k1_empty", 64'(fifo_empty), 64'd1);
        @(negedge clk);
        check("t1_k2_strobe", 64'(out_clk_en), 64'd1);
        @(negedge clk);
        check("t1_k3_strobe", 64'(out_clk_en), 64'd0);
        check("t1_k3_busy", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_k4_busy", 64'(busy), 64'd0);
        drain("t1_drain", 50);

        // Blank gating: opcode 1 held until screen_blank
        push(32'hABC0_0001, 32'h0000_00B1, 1'b1, 1'b1);
        no_strobe_for("t2_hold_no_strobe", 20);
        check("t2_hold_busy", 64'(busy), 64'd1);
        check("t2_hold_dataA", 64'(out_dataA), 64'hABC0_0001);
        screen_blank = 1'b1;
        @(negedge clk);
        check("t2_open_strobe", 64'(out_clk_en), 64'd1);
        drain("t2_drain", 50);
        screen_blank = 1'b0;

        // Full/overflow: park an opcode-1 in CHECK so 16 pushes fill the FIFO
        unit_ready = 1'b0;
        push(32'h0000_0001, 32'h0000_C0DE, 1'b1, 1'b1);
        @(negedge clk);
        check("t3_parked_empty", 64'(fifo_empty), 64'd1);
        for (int v = 0; v < 16; v++) begin
            push(32'h0000_0000, 32'(v), 1'b1, 1'b0);
            if (v == 14) check("t3_not_full_at_15", 64'(fifo_full), 64'd0);
        end
        check("t3_full_after_16", 64'(fifo_full), 64'd1);
        push(32'h0000_0000, 32'd16, 1'b0, 1'b0);
        check("t3_full_after_17", 64'(fifo_full), 64'd1);
        screen_blank = 1'b1;
        unit_ready   = 1'b1;
        drain("t3_drain", 300);
        no_strobe_for("t3_no_extra", 10);
        check("t3_drop_zero", 64'(drop_count), 64'd0);
        screen_blank = 1'b0;

        // Invalid opcodes: drop counter saturates at 255, nothing issued
        for (int i = 0; i < 10; i++) push((32'(i) << 4) | 32'h7, 32'(i), 1'b0, 1'b1);
        drain("t4_drain10", 50);
        check("t4_drop_10", 64'(drop_count), 64'd10);
        for (int i = 10; i < 300; i++) push((32'(i) << 4) | 32'h7, 32'(i), 1'b0, 1'b1);
        drain("t4_drain300", 100);
        check("t4_drop_sat", 64'(drop_count), 64'd255);
        push(32'h0000_000F, 32'hF00D, 1'b0, 1'b1);
        drain("t4_drain_nop", 50);
        check("t4_drop_sat_nop", 64'(drop_count), 64'd255);
        coproc_ready = 1'b1;
        push(32'h5555_0003, 32'hC0C0_C0C0, 1'b1, 1'b1);
        drain("t4_drain_poly", 50);
        coproc_ready = 1'b0;

        // Back-pressure: unit_ready low for 10 cycles after the first issue
        push(32'h0000_00A0, 32'h0000_00A0, 1'b1, 1'b1);
        push(32'h0000_00B0, 32'h0000_00A1, 1'b1, 1'b1);
        n = 0;
        while (!out_clk_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t5_first_strobe_timeout", 64'(n >= 20), 64'd0);
        unit_ready = 1'b0;
        no_strobe_for("t5_held_no_strobe", 10);
        unit_ready = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_clk_en && n < 20);
        check("t5_gap_after_ready", 64'(n), 64'd3);
        drain("t5_drain", 50);

        // Reset mid-ISSUE with 3 entries queued
        unit_ready = 1'b0;
        push(32'h0000_0000, 32'h0000_00D0, 1'b1, 1'b1);
        push(32'h0000_0000, 32'h0000_00D1, 1'b0, 1'b1);
        push(32'h0000_0000, 32'h0000_00D2, 1'b0, 1'b1);
        push(32'h0000_0000, 32'h0000_00D3, 1'b0, 1'b1);
        check("t6_queued_not_empty", 64'(fifo_empty), 64'd0);
        unit_ready = 1'b1;
        @(negedge clk);
        check("t6_in_issue", 64'(out_clk_en), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_strobe", 64'(out_clk_en), 64'd0);
        check("t6_rst_empty", 64'(fifo_empty), 64'd1);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_dataB", 64'(out_dataB), 64'd0);
        check("t6_rst_drop", 64'(drop_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        no_strobe_for("t6_no_issue_after_reset", 20);
        check("t6_still_empty", 64'(fifo_empty), 64'd1);
        push(32'h0000_0000, 32'h0000_00E0, 1'b1, 1'b1);
        drain("t6_drain", 50);

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
